// File: rtl/soc_node_map_ctrl_if.sv
// soc_node_map_ctrl_if: APB programming port of the node address-map controller
interface soc_node_map_ctrl_if;
    logic [7:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pready, pslverr);
    modport slave (input paddr, psel, penable, pwrite, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/soc_node_map_ctrl.sv
// soc_node_map_ctrl: APB-programmed crossbar address map with quiesce/drain/swap commit
// Defining SOC_NODE_MAP_TIMEOUT_EN adds a drain timeout that abandons the commit.
module soc_node_map_ctrl #(
    parameter int N_SLAVES        = 4,
    parameter int N_MASTERS       = 3,
    parameter int AXI_AW          = 32,
    parameter int MAX_OUTSTANDING = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    soc_node_map_ctrl_if.slave            apb,
    input  logic [N_SLAVES-1:0]           aw_hs_i,
    input  logic [N_SLAVES-1:0]           b_hs_i,
    input  logic [N_SLAVES-1:0]           ar_hs_i,
    input  logic [N_SLAVES-1:0]           rlast_hs_i,
    output logic [N_SLAVES-1:0]           gate_o,
    output logic [N_MASTERS*AXI_AW-1:0]   start_addr_o,
    output logic [N_MASTERS*AXI_AW-1:0]   end_addr_o,
    output logic                          busy_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = N_MASTERS > 1 ? $clog2(N_MASTERS) : 1;
    localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);
    typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] wcnt_q [N_SLAVES];
    logic [CW-1:0] wcnt_d [N_SLAVES];
    logic [CW-1:0] rcnt_q [N_SLAVES];
    logic [CW-1:0] rcnt_d [N_SLAVES];
    logic [N_SLAVES-1:0] gate_q, gate_d, wz, rz;
    logic [AXI_AW-1:0] sh_start_q [N_MASTERS];
    logic [AXI_AW-1:0] sh_end_q [N_MASTERS];
    logic [AXI_AW-1:0] act_start_q [N_MASTERS];
    logic [AXI_AW-1:0] act_end_q [N_MASTERS];
    logic [IW-1:0] idx;
    logic shadow_hit, ctrl_hit, stat_hit, access, err, we, commit, drained, to_hit, to_flag;
    logic [31:0] rdata;

    function automatic logic [AXI_AW-1:0] rst_start(int i);
        return AXI_AW'(i == 0 ? 32'h1A00_0000 : i == 1 ? 32'h2000_0000 : i == 2 ? 32'h4000_0000 : 32'h0);
    endfunction

    function automatic logic [AXI_AW-1:0] rst_end(int i);
        return AXI_AW'(i == 0 ? 32'h1FFF_FFFF : i == 1 ? 32'h3FFF_FFFF : i == 2 ? 32'hFFFF_FFFF : 32'h0);
    endfunction

    assign idx        = apb.paddr[3 +: IW];
    assign shadow_hit = apb.paddr[1:0] == 2'b00 && apb.paddr[7:3] < 5'(N_MASTERS);
    assign ctrl_hit   = apb.paddr == 8'h40;
    assign stat_hit   = apb.paddr == 8'h44;
    assign access     = apb.psel & apb.penable;
    // Rule and commit writes are refused while a commit is in flight
    assign err        = access & (~(shadow_hit | ctrl_hit | stat_hit) | (apb.pwrite & busy_o & (shadow_hit | ctrl_hit)));
    assign we         = access & apb.pwrite & ~err;
    assign commit     = we & ctrl_hit & apb.pwdata[0];
    assign rdata      = shadow_hit ? 32'(apb.paddr[2] ? sh_end_q[idx] : sh_start_q[idx]) :
                        stat_hit ? {30'b0, to_flag, busy_o} : 32'h0;
    assign apb.prdata  = apb.psel & ~apb.pwrite ? rdata : 32'h0;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = err;
    assign busy_o      = state_q != IDLE;
    assign gate_o      = gate_q;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_rule
        assign start_addr_o[i*AXI_AW +: AXI_AW] = act_start_q[i];
        assign end_addr_o[i*AXI_AW +: AXI_AW]   = act_end_q[i];
    end

    always_comb begin
        drained = 1'b1;
        for (int s = 0; s < N_SLAVES; s++) begin
            wz[s] = wcnt_q[s] == '0;
            rz[s] = rcnt_q[s] == '0;
            wcnt_d[s] = (aw_hs_i[s] & ~b_hs_i[s] & wcnt_q[s] != CMAX) ? wcnt_q[s] + CW'(1) :
                        (b_hs_i[s] & ~aw_hs_i[s] & ~wz[s]) ? wcnt_q[s] - CW'(1) : wcnt_q[s];
            rcnt_d[s] = (ar_hs_i[s] & ~rlast_hs_i[s] & rcnt_q[s] != CMAX) ? rcnt_q[s] + CW'(1) :
                        (rlast_hs_i[s] & ~ar_hs_i[s] & ~rz[s]) ? rcnt_q[s] - CW'(1) : rcnt_q[s];
            drained = drained & wcnt_d[s] == '0 & rcnt_d[s] == '0;
        end
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = commit ? DRAIN : IDLE;
            DRAIN:   state_d = drained ? SWAP : to_hit ? IDLE : DRAIN;
            SWAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        for (int s = 0; s < N_SLAVES; s++)
            gate_d[s] = state_d != IDLE | wcnt_d[s] == CMAX | rcnt_d[s] == CMAX;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gate_q  <= '0;
            for (int s = 0; s < N_SLAVES; s++) begin
                wcnt_q[s] <= '0;
                rcnt_q[s] <= '0;
            end
            for (int i = 0; i < N_MASTERS; i++) begin
                sh_start_q[i]  <= rst_start(i);
                sh_end_q[i]    <= rst_end(i);
                act_start_q[i] <= rst_start(i);
                act_end_q[i]   <= rst_end(i);
            end
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            if (we & shadow_hit & apb.paddr[2]) sh_end_q[idx] <= AXI_AW'(apb.pwdata);
            if (we & shadow_hit & ~apb.paddr[2]) sh_start_q[idx] <= AXI_AW'(apb.pwdata);
            if (state_q == SWAP) begin
                act_start_q <= sh_start_q;
                act_end_q   <= sh_end_q;
            end
        end
    end

`ifdef SOC_NODE_MAP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tcnt_q;
    assign to_hit = tcnt_q == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_q  <= '0;
            to_flag <= 1'b0;
        end else begin
            tcnt_q  <= state_q == DRAIN ? tcnt_q + TW'(1) : '0;
            to_flag <= (state_q == DRAIN & ~drained & to_hit) | (to_flag & ~(we & stat_hit & apb.pwdata[1]));
        end
    end
`else
    assign to_hit  = 1'b0;
    assign to_flag = 1'b0;
`endif

    // Completions with nothing outstanding are protocol errors; the count is held
    assert property (@(posedge clk_i) disable iff (!rst_ni) (b_hs_i & ~aw_hs_i & wz) == '0);
    assert property (@(posedge clk_i) disable iff (!rst_ni) (rlast_hs_i & ~ar_hs_i & rz) == '0);
endmodule
